// File: rtl/mem_init_seq_if.sv
// Host request channel and memory request port of the init sequencer.
// master = host side (drives requests, observes the memory port); slave = sequencer.
interface mem_init_seq_if #(
  parameter int addr_width = 16,
  parameter int data_width = 8
) ();
  logic                  host_req;
  logic                  host_we;
  logic [addr_width-1:0] host_addr;
  logic [data_width-1:0] host_wdata;
  logic                  host_ready;

  logic                  mem_en;
  logic                  mem_we;
  logic [addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_wdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_ready,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_init_seq.sv
// Memory init sequencer: on start, writes fill_value to every address once per cycle,
// otherwise forwards host requests to the memory port with one cycle of latency.
module mem_init_seq #(
  parameter int addr_width = 16,
  parameter int data_width = 8,
  parameter int fill_value = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  mem_init_seq_if.slave  bus,
  output logic           busy,
  output logic           done
);
  localparam logic [data_width-1:0] fill_data  = data_width'(fill_value);
  // One extra bit keeps the terminal compare exact even for addr_width = 1.
  localparam logic [addr_width:0]   last_index = {1'b0, {addr_width{1'b1}}};

  typedef enum logic [1:0] {IDLE, INIT, READY} state_t;

  state_t              state;
  logic [addr_width:0] count;
  logic [addr_width:0] count_inc;
  logic                accept;

  assign count_inc      = count + 1'b1;
  assign bus.host_ready = (state != INIT) && !start;
  assign accept         = bus.host_req && bus.host_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, READY: begin
          if (start) begin
            // The first sweep write goes out on the same edge that samples start.
            state         <= INIT;
            count         <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= fill_data;
          end else if (accept) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.host_we;
            bus.mem_addr  <= bus.host_addr;
            bus.mem_wdata <= bus.host_wdata;
          end
        end
        INIT: begin
          // count is the address currently presented; start is ignored here.
          if (count == last_index) begin
            state <= READY;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            count         <= count_inc;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= count_inc[addr_width-1:0];
            bus.mem_wdata <= fill_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_init_seq.sv
// Randomized and directed checks of mem_init_seq against a transaction-queue model.
module tb_mem_init_seq;
  localparam logic [7:0] FILL4 = 8'hA5;
  localparam logic [7:0] FILL1 = 8'h3C;

  logic clk = 1'b0;
  logic rst_n4 = 1'b0, rst_n1 = 1'b0;
  logic start4 = 1'b0, start1 = 1'b0;
  logic busy4, done4, busy1, done1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_init_seq_if #(.addr_width(4), .data_width(8)) bus4 ();
  mem_init_seq_if #(.addr_width(1), .data_width(8)) bus1 ();

  mem_init_seq #(.addr_width(4), .data_width(8), .fill_value(8'hA5)) dut4 (
    .clk(clk), .rst_n(rst_n4), .start(start4), .bus(bus4), .busy(busy4), .done(done4));
  mem_init_seq #(.addr_width(1), .data_width(8), .fill_value(8'h3C)) dut1 (
    .clk(clk), .rst_n(rst_n1), .start(start1), .bus(bus1), .busy(busy1), .done(done1));

  // Model: queue of memory transactions the DUT owes, one presented per cycle.
  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       sweep;
    logic       last;
  } txn_t;

  txn_t       q[$];
  logic       m_en, m_we, m_busy, m_last, m_done;
  logic [3:0] m_addr;
  logic [7:0] m_wdata;

  task automatic model_reset();
    q.delete();
    m_en = 0; m_we = 0; m_busy = 0; m_last = 0; m_done = 0;
    m_addr = '0; m_wdata = '0;
  endtask

  // Drive one cycle of inputs on dut4, then check ready now and outputs after the edge.
  task automatic cycle4(input logic s, input logic rq, input logic w,
                        input logic [3:0] a, input logic [7:0] d);
    logic clr;
    txn_t t;
    clr = 0;
    start4 = s; bus4.host_req = rq; bus4.host_we = w; bus4.host_addr = a; bus4.host_wdata = d;
    #1;
    checks++;
    if (bus4.host_ready !== (!m_busy && !s)) begin
      errors++;
      $display("FAIL host_ready t=%0t got %b exp %b", $time, bus4.host_ready, !m_busy && !s);
    end
    if (!m_busy && s) begin
      for (int i = 0; i < 16; i++) begin
        t = '{we: 1'b1, addr: i[3:0], wdata: FILL4, sweep: 1'b1, last: (i == 15)};
        q.push_back(t);
      end
      clr = 1;
    end else if (!m_busy && rq) begin
      t = '{we: w, addr: a, wdata: d, sweep: 1'b0, last: 1'b0};
      q.push_back(t);
    end
    @(posedge clk); #1;
    if (m_last) m_done = 1;
    if (clr) m_done = 0;
    if (q.size() > 0) begin
      t = q.pop_front();
      m_en = 1; m_we = t.we; m_addr = t.addr; m_wdata = t.wdata;
      m_busy = t.sweep; m_last = t.last;
    end else begin
      m_en = 0; m_we = 0; m_busy = 0; m_last = 0;
    end
    if (bus4.mem_en)
      $display("txn t=%0t we=%b addr=%h data=%h busy=%b", $time, bus4.mem_we,
               bus4.mem_addr, bus4.mem_wdata, busy4);
    checks++;
    if (bus4.mem_en !== m_en) begin errors++;
      $display("FAIL mem_en t=%0t got %b exp %b", $time, bus4.mem_en, m_en); end
    checks++;
    if (bus4.mem_we !== m_we) begin errors++;
      $display("FAIL mem_we t=%0t got %b exp %b", $time, bus4.mem_we, m_we); end
    checks++;
    if (bus4.mem_addr !== m_addr) begin errors++;
      $display("FAIL mem_addr t=%0t got %h exp %h", $time, bus4.mem_addr, m_addr); end
    checks++;
    if (bus4.mem_wdata !== m_wdata) begin errors++;
      $display("FAIL mem_wdata t=%0t got %h exp %h", $time, bus4.mem_wdata, m_wdata); end
    checks++;
    if (busy4 !== m_busy) begin errors++;
      $display("FAIL busy t=%0t got %b exp %b", $time, busy4, m_busy); end
    checks++;
    if (done4 !== m_done) begin errors++;
      $display("FAIL done t=%0t got %b exp %b", $time, done4, m_done); end
  endtask

  task automatic idle4(input int n);
    for (int i = 0; i < n; i++) cycle4(0, 0, 0, 4'h0, 8'h00);
  endtask

  task automatic reset4();
    rst_n4 = 0; start4 = 0; bus4.host_req = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n4 = 1;
  endtask

  task automatic test_reset();
    start4 = 0; bus4.host_req = 0; bus4.host_we = 0; bus4.host_addr = '0; bus4.host_wdata = '0;
    start1 = 0; bus1.host_req = 0; bus1.host_we = 0; bus1.host_addr = '0; bus1.host_wdata = '0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({bus4.mem_en, bus4.mem_we, bus4.mem_addr, bus4.mem_wdata, busy4, done4} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b we=%b a=%h d=%h busy=%b done=%b exp all 0",
               bus4.mem_en, bus4.mem_we, bus4.mem_addr, bus4.mem_wdata, busy4, done4);
    end
    checks++;
    if ({bus1.mem_en, busy1, done1} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs_aw1 got %b exp 000", {bus1.mem_en, busy1, done1});
    end
    rst_n4 = 1; rst_n1 = 1;
    #1;
    checks++;
    if (bus4.host_ready !== 1'b1) begin errors++;
      $display("FAIL reset_host_ready got %b exp 1", bus4.host_ready); end
  endtask

  task automatic test_sweep();
    cycle4(1, 0, 0, 4'h0, 8'h00);
    idle4(18);
  endtask

  task automatic test_host_access();
    cycle4(0, 1, 1, 4'h3, 8'h5C);
    cycle4(0, 1, 0, 4'h7, 8'($urandom));
    idle4(2);
  endtask

  task automatic test_start_priority();
    reset4();
    cycle4(1, 1, 1, 4'h9, 8'h77);
    for (int i = 0; i < 17; i++) cycle4(0, 1, 1, 4'h9, 8'h77);
    idle4(2);
  endtask

  task automatic test_start_ignored();
    cycle4(1, 0, 0, 4'h0, 8'h00);
    for (int i = 1; i < 20; i++) cycle4(i == 5, $urandom_range(0, 1), 1, 4'($urandom), 8'($urandom));
    idle4(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      cycle4($urandom_range(0, 39) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
             4'($urandom), 8'($urandom));
    idle4(18);
  endtask

  task automatic test_reset_mid_sweep();
    idle4(1);
    cycle4(1, 0, 0, 4'h0, 8'h00);
    idle4(9);
    #3;
    rst_n4 = 0;
    #1;
    checks++;
    if ({bus4.mem_en, busy4, done4} !== 3'b000) begin errors++;
      $display("FAIL async_reset got en/busy/done=%b exp 000", {bus4.mem_en, busy4, done4}); end
    checks++;
    if (bus4.mem_addr !== 4'h0) begin errors++;
      $display("FAIL async_reset_addr got %h exp 0", bus4.mem_addr); end
    model_reset();
    @(posedge clk); #1;
    rst_n4 = 1;
    #1;
    checks++;
    if (bus4.host_ready !== 1'b1) begin errors++;
      $display("FAIL post_reset_host_ready got %b exp 1", bus4.host_ready); end
    idle4(3);
    cycle4(0, 1, 1, 4'hE, 8'h42);
    idle4(2);
  endtask

  task automatic test_small_resweep();
    for (int pass = 0; pass < 2; pass++) begin
      start1 = 1;
      @(posedge clk); #1;
      start1 = 0;
      for (int i = 0; i < 2; i++) begin
        $display("txn aw1 pass=%0d we=%b addr=%h data=%h", pass, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata);
        checks++;
        if ({bus1.mem_en, bus1.mem_we, busy1, done1} !== 4'b1110) begin errors++;
          $display("FAIL aw1_sweep_flags pass=%0d i=%0d got %b exp 1110", pass, i,
                   {bus1.mem_en, bus1.mem_we, busy1, done1}); end
        checks++;
        if (bus1.mem_addr !== i[0]) begin errors++;
          $display("FAIL aw1_addr pass=%0d got %h exp %h", pass, bus1.mem_addr, i[0]); end
        checks++;
        if (bus1.mem_wdata !== FILL1) begin errors++;
          $display("FAIL aw1_wdata got %h exp %h", bus1.mem_wdata, FILL1); end
        @(posedge clk); #1;
      end
      checks++;
      if ({bus1.mem_en, busy1, done1} !== 3'b001) begin errors++;
        $display("FAIL aw1_end pass=%0d got en/busy/done=%b exp 001", pass, {bus1.mem_en, busy1, done1}); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_host_access();
    test_start_priority();
    test_start_ignored();
    test_random();
    test_reset_mid_sweep();
    test_small_resweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
